// File: rtl/ica_fxp_pkg.sv
// ica_fxp_pkg
// Shared fixed-point definitions for the FastICA datapath blocks:
//   - default element width, vector length and Q-format fraction bits
//   - accumulator width helper sized so a full dot product cannot overflow
//   - sat_to_data: clamp a wide signed value into a signed N-bit range
//   - dot-product FSM state encoding
package ica_fxp_pkg;

    localparam int DATA_WIDTH_DEF = 16;
    localparam int EXT_DIM_DEF    = 4;
    localparam int FRAC_BITS_DEF  = 12;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MAC   = 2'd1,
        ST_SCALE = 2'd2,
        ST_DONE  = 2'd3
    } dot_state_e;

    // Full-width product plus one growth bit per doubling of terms, plus one
    // spare so the sum of EXT_DIM worst-case products always fits.
    function automatic int acc_width(input int dw, input int dim);
        return 2 * dw + $clog2(dim) + 1;
    endfunction

    // Works on a 128-bit signed carrier so any parameterisation up to that
    // width can share one helper; caller keeps the low dw bits.
    function automatic logic signed [63:0] sat_to_data(input logic signed [127:0] v,
                                                       input int unsigned        dw);
        logic signed [127:0] max_v;
        logic signed [127:0] min_v;
        max_v = (128'sd1 <<< (dw - 1)) - 128'sd1;
        min_v = -(128'sd1 <<< (dw - 1));
        if (v > max_v) begin
            return max_v[63:0];
        end else if (v < min_v) begin
            return min_v[63:0];
        end
        return v[63:0];
    endfunction

endpackage

// File: rtl/dot_product_unit_fxp_mac.sv
// fxp_mac
// Registered signed multiply-accumulate.
//   clk, rstn : clock, synchronous active-low reset
//   clr_i     : synchronous clear of the accumulator (wins over en_i)
//   en_i      : add a_i*b_i into the accumulator this edge
//   a_i, b_i  : signed operands, DATA_WIDTH bits each
//   acc_o     : signed accumulator, ACC_WIDTH bits
module fxp_mac #(
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 35
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         clr_i,
    input  logic                         en_i,
    input  logic signed [DATA_WIDTH-1:0] a_i,
    input  logic signed [DATA_WIDTH-1:0] b_i,
    output logic signed [ACC_WIDTH-1:0]  acc_o
);

    logic signed [2*DATA_WIDTH-1:0] prod;
    logic signed [ACC_WIDTH-1:0]    acc_q;
    logic signed [ACC_WIDTH-1:0]    acc_d;

    assign prod  = a_i * b_i;
    assign acc_d = acc_q + ACC_WIDTH'(prod);
    assign acc_o = acc_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            acc_q <= '0;
        end else if (clr_i) begin
            acc_q <= '0;
        end else if (en_i) begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/dot_product_unit.sv
// dot_product_unit
// Shared fixed-point dot-product responder. Latches two EXT_DIM-element
// signed vectors on a level start request, accumulates their products one
// element per cycle through a single MAC, then scales by FRAC_BITS with
// floor truncation and saturates to DATA_WIDTH.
//   clk, rstn          : clock, synchronous active-low reset
//   rstn_dot           : synchronous active-low per-operation clear
//   start_dot_product  : level request, held until done is seen
//   vector_a, vector_b : packed vectors, element i at [i*DATA_WIDTH +: DATA_WIDTH]
//   dot_product_done   : level, high from result valid until start drops
//   dot_product_result : signed scaled result, held until next latch/clear
//   busy               : high while in MAC or SCALE
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for start; latches vectors and clears MAC on start
// ST_MAC   | one element product accumulated per edge
// ST_SCALE | shift, saturate, register result, raise done
// ST_DONE  | hold done until start drops, then back to idle
module dot_product_unit
    import ica_fxp_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int EXT_DIM    = EXT_DIM_DEF,
    parameter int FRAC_BITS  = FRAC_BITS_DEF
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          rstn_dot,
    input  logic                          start_dot_product,
    input  logic [DATA_WIDTH*EXT_DIM-1:0] vector_a,
    input  logic [DATA_WIDTH*EXT_DIM-1:0] vector_b,
    output logic                          dot_product_done,
    output logic [DATA_WIDTH-1:0]         dot_product_result,
    output logic                          busy
);

    localparam int ACC_WIDTH = acc_width(DATA_WIDTH, EXT_DIM);
    localparam int IDX_W     = (EXT_DIM > 1) ? $clog2(EXT_DIM) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(EXT_DIM - 1);

    dot_state_e                    state_q;
    logic [IDX_W-1:0]              idx_q;
    logic [DATA_WIDTH*EXT_DIM-1:0] a_q;
    logic [DATA_WIDTH*EXT_DIM-1:0] b_q;
    logic                          done_q;
    logic [DATA_WIDTH-1:0]         result_q;
    logic                          busy_q;

    logic signed [DATA_WIDTH-1:0]  a_sel;
    logic signed [DATA_WIDTH-1:0]  b_sel;
    logic                          mac_clr;
    logic                          mac_en;
    logic signed [ACC_WIDTH-1:0]   acc;
    logic signed [ACC_WIDTH-1:0]   acc_shr;
    logic signed [127:0]           acc_ext;
    logic signed [63:0]            sat_full;
    logic [DATA_WIDTH-1:0]         result_d;

    assign a_sel = a_q[idx_q*DATA_WIDTH +: DATA_WIDTH];
    assign b_sel = b_q[idx_q*DATA_WIDTH +: DATA_WIDTH];

    // The accumulator is cleared on the latch edge so MAC starts from zero.
    assign mac_clr = !rstn_dot || ((state_q == ST_IDLE) && start_dot_product);
    assign mac_en  = (state_q == ST_MAC);

    fxp_mac #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH)
    ) u_mac (
        .clk   (clk),
        .rstn  (rstn),
        .clr_i (mac_clr),
        .en_i  (mac_en),
        .a_i   (a_sel),
        .b_i   (b_sel),
        .acc_o (acc)
    );

    // Arithmetic shift floors toward -inf; no rounding is applied.
    assign acc_shr  = acc >>> FRAC_BITS;
    assign acc_ext  = 128'(acc_shr);
    assign sat_full = sat_to_data(acc_ext, DATA_WIDTH);
    assign result_d = sat_full[DATA_WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            done_q   <= 1'b0;
            result_q <= '0;
            busy_q   <= 1'b0;
        end else if (!rstn_dot) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            done_q   <= 1'b0;
            result_q <= '0;
            busy_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_dot_product) begin
                        a_q     <= vector_a;
                        b_q     <= vector_b;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_MAC;
                    end
                end
                ST_MAC: begin
                    if (idx_q == IDX_LAST) begin
                        idx_q   <= '0;
                        state_q <= ST_SCALE;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                ST_SCALE: begin
                    result_q <= result_d;
                    done_q   <= 1'b1;
                    busy_q   <= 1'b0;
                    state_q  <= ST_DONE;
                end
                ST_DONE: begin
                    // No retrigger while start stays high: the initiator
                    // must drop it before a new request is accepted.
                    if (!start_dot_product) begin
                        done_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign dot_product_done   = done_q;
    assign dot_product_result = result_q;
    assign busy               = busy_q;

endmodule

// File: tb/tb_dot_product_unit.sv
// tb_dot_product_unit
// Directed vector table plus hand-written handshake/clear sequences for
// dot_product_unit at default parameters (Q4.12, 4 elements, 16-bit).
module tb_dot_product_unit;

    localparam int DW = 16;
    localparam int N  = 4;

    logic            clk = 1'b0;
    logic            rstn;
    logic            rstn_dot;
    logic            start;
    logic [DW*N-1:0] va;
    logic [DW*N-1:0] vb;
    logic            done;
    logic [DW-1:0]   res;
    logic            busy;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    dot_product_unit dut (
        .clk                (clk),
        .rstn               (rstn),
        .rstn_dot           (rstn_dot),
        .start_dot_product  (start),
        .vector_a           (va),
        .vector_b           (vb),
        .dot_product_done   (done),
        .dot_product_result (res),
        .busy               (busy)
    );

    typedef struct {
        string           name;
        logic [DW*N-1:0] a;
        logic [DW*N-1:0] b;
        logic [DW-1:0]   exp;
    } vec_t;

    function automatic logic [DW*N-1:0] pk(input int e0, input int e1, input int e2, input int e3);
        return {16'(e3), 16'(e2), 16'(e1), 16'(e0)};
    endfunction

    // Independent reference: 64-bit integer dot product, floor divide, clamp.
    function automatic logic [DW-1:0] ref_dot(input logic [DW*N-1:0] a, input logic [DW*N-1:0] b);
        longint s;
        logic signed [DW-1:0] ea;
        logic signed [DW-1:0] eb;
        s = 0;
        for (int k = 0; k < N; k++) begin
            ea = a[k*DW +: DW];
            eb = b[k*DW +: DW];
            s += longint'(ea) * longint'(eb);
        end
        s = s >>> 12;
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
        return 16'(s);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Raises start, scrambles the inputs right after the latch edge, waits
    // (bounded) for done. lat counts edges from the latch edge inclusive.
    task automatic run_op(input logic [DW*N-1:0] a, input logic [DW*N-1:0] b,
                          input bit drop_early, output logic [DW-1:0] r, output int lat);
        va    = a;
        vb    = b;
        start = 1'b1;
        tick();
        va = {$urandom, $urandom};
        vb = {$urandom, $urandom};
        chk("busy_after_latch", 32'(busy), 32'd1);
        if (drop_early) start = 1'b0;
        lat = 1;
        while (!done && lat < 20) begin
            tick();
            lat++;
        end
        r = res;
    endtask

    task automatic end_op(input string name);
        start = 1'b0;
        tick();
        chk({name, "_done_fall"}, 32'(done), 32'd0);
    endtask

    vec_t tbl[$];

    initial begin
        logic [DW-1:0]   r;
        logic [DW-1:0]   held;
        logic [DW*N-1:0] wa;
        logic [DW*N-1:0] zb;
        int              lat;

        rstn     = 1'b0;
        rstn_dot = 1'b1;
        start    = 1'b0;
        va       = '0;
        vb       = '0;
        tick();
        tick();
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_result", 32'(res), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rstn = 1'b1;
        tick();

        tbl.push_back('{"basic",   pk(4096, 8192, 2048, 0), pk(4096, 4096, 8192, 0), 16'h4000});
        tbl.push_back('{"sat_pos", pk(28672, 28672, 28672, 28672), pk(28672, 28672, 28672, 28672), 16'h7FFF});
        tbl.push_back('{"sat_neg", pk(28672, 28672, 28672, 28672), pk(-28672, -28672, -28672, -28672), 16'h8000});
        tbl.push_back('{"tiny_pos", pk(1, 0, 0, 0), pk(1, 0, 0, 0), 16'h0000});
        tbl.push_back('{"tiny_neg", pk(-1, 0, 0, 0), pk(1, 0, 0, 0), 16'hFFFF});
        tbl.push_back('{"neg_half", pk(-4096, 100, 200, 300), pk(2048, 0, 0, 0), 16'hF800});
        tbl.push_back('{"cancel", pk(4096, 4096, 4096, 4096), pk(4096, -4096, 4096, -4096), 16'h0000});
        tbl.push_back('{"trunc_pos", pk(1000, 2000, 3000, 4000), pk(-500, 700, -900, 1100), 16'd634});
        tbl.push_back('{"trunc_neg", pk(1000, 2000, 3000, 4000), pk(500, -700, 900, -1100), 16'hFD85});

        foreach (tbl[i]) begin
            run_op(tbl[i].a, tbl[i].b, 1'b0, r, lat);
            chk({tbl[i].name, "_lat"}, 32'(lat), 32'd6);
            chk({tbl[i].name, "_res"}, 32'(r), 32'(tbl[i].exp));
            chk({tbl[i].name, "_busy_done"}, 32'(busy), 32'd0);
            end_op(tbl[i].name);
            chk({tbl[i].name, "_res_held"}, 32'(res), 32'(tbl[i].exp));
        end

        // Start held 10 cycles past done: one result, no retrigger.
        run_op(pk(4096, 8192, 2048, 0), pk(4096, 4096, 8192, 0), 1'b0, r, lat);
        chk("hold_lat", 32'(lat), 32'd6);
        for (int c = 0; c < 10; c++) begin
            tick();
            chk("hold_done", 32'(done), 32'd1);
            chk("hold_res", 32'(res), 32'h4000);
            chk("hold_busy", 32'(busy), 32'd0);
        end
        end_op("hold");

        // Start dropped during MAC: done still arrives and pulses one cycle.
        run_op(pk(8192, 0, 0, 0), pk(4096, 0, 0, 0), 1'b1, r, lat);
        chk("drop_lat", 32'(lat), 32'd6);
        chk("drop_res", 32'(r), 32'h2000);
        tick();
        chk("drop_pulse_end", 32'(done), 32'd0);
        tick();
        chk("drop_no_retrig", 32'(busy), 32'd0);

        // rstn_dot low while MAC sits at idx=2.
        va    = pk(4096, 4096, 4096, 4096);
        vb    = pk(4096, 4096, 4096, 4096);
        start = 1'b1;
        tick();
        tick();
        tick();
        rstn_dot = 1'b0;
        start    = 1'b0;
        tick();
        chk("clr_done", 32'(done), 32'd0);
        chk("clr_res", 32'(res), 32'd0);
        chk("clr_busy", 32'(busy), 32'd0);
        rstn_dot = 1'b1;
        tick();
        run_op(pk(4096, 4096, 4096, 4096), pk(4096, 4096, 4096, 4096), 1'b0, r, lat);
        chk("fresh_lat", 32'(lat), 32'd6);
        chk("fresh_res", 32'(r), 32'h4000);

        // Full reset while in DONE with start still high.
        rstn = 1'b0;
        tick();
        chk("rstdone_done", 32'(done), 32'd0);
        chk("rstdone_res", 32'(res), 32'd0);
        chk("rstdone_busy", 32'(busy), 32'd0);
        rstn  = 1'b1;
        start = 1'b0;
        tick();

        // Initiator emulation: 3 W rows x 4 Z columns, rstn_dot between each.
        for (int w = 0; w < 3; w++) begin
            wa = pk($urandom_range(0, 16383) - 8192, $urandom_range(0, 16383) - 8192,
                    $urandom_range(0, 16383) - 8192, $urandom_range(0, 16383) - 8192);
            for (int z = 0; z < 4; z++) begin
                zb = pk($urandom_range(0, 32767) - 16384, $urandom_range(0, 32767) - 16384,
                        $urandom_range(0, 32767) - 16384, $urandom_range(0, 32767) - 16384);
                held = ref_dot(wa, zb);
                run_op(wa, zb, 1'b0, r, lat);
                chk("wz_lat", 32'(lat), 32'd6);
                chk("wz_res", 32'(r), 32'(held));
                end_op("wz");
                rstn_dot = 1'b0;
                tick();
                chk("wz_clr_res", 32'(res), 32'd0);
                chk("wz_clr_done", 32'(done), 32'd0);
                rstn_dot = 1'b1;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
